// File: rtl/color_grid_pkg.sv
// Shared constants and types for the colour grid manager: frame header tag,
// error codes, display modes, command FSM states and colour byte count helper.
package color_grid_pkg;

    localparam logic [1:0] HDR_TAG      = 2'b10;
    localparam int         REGION_IDX_W = 3;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_STRAY   = 2'd1,
        ERR_RANGE   = 2'd2,
        ERR_RESTART = 2'd3
    } err_e;

    typedef enum logic [1:0] {
        MODE_SINGLE = 2'd0,
        MODE_VSPLIT = 2'd1,
        MODE_HSPLIT = 2'd2,
        MODE_GRID   = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP,
        ST_HDR,
        ST_DATA,
        ST_WRITE,
        ST_NOTIFY
    } state_e;

    function automatic int colorBytes(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/color_grid_region_counter.sv
// One screen axis: counts steps within a region and advances a region index
// that saturates at the last region.
module color_grid_region_counter
    import color_grid_pkg::*;
#(
    parameter int REGIONS = 4,
    parameter int SPAN    = 160
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    step_i,
    output logic [REGION_IDX_W-1:0] idx_o
);

    localparam int SUB_W = (SPAN > 1) ? $clog2(SPAN) : 1;

    logic [SUB_W-1:0]        sub_q, sub_d;
    logic [REGION_IDX_W-1:0] idx_q, idx_d;

    always_comb begin
        sub_d = sub_q;
        idx_d = idx_q;
        if (clear_i) begin
            sub_d = '0;
            idx_d = '0;
        end else if (step_i) begin
            if (sub_q == SUB_W'(SPAN - 1)) begin
                sub_d = '0;
                if (idx_q != REGION_IDX_W'(REGIONS - 1)) begin
                    idx_d = idx_q + 1'b1;
                end
            end else begin
                sub_d = sub_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sub_q <= '0;
            idx_q <= '0;
        end else begin
            sub_q <= sub_d;
            idx_q <= idx_d;
        end
    end

    assign idx_o = idx_q;

endmodule

// File: rtl/color_grid_manager.sv
// Decodes framed colour commands from the UART RX FIFO into a per-region colour
// table and paints pixels from it. Define COLOR_GRID_SHADOW_EN for tear-free updates.
module color_grid_manager
    import color_grid_pkg::*;
#(
    parameter int UART_DATA_WIDTH = 8,
    parameter int COLOR_WIDTH     = 12,
    parameter int H_REGIONS       = 4,
    parameter int V_REGIONS       = 4,
    parameter int H_ACTIVE        = 640,
    parameter int V_ACTIVE        = 480,
    parameter int REG_IDX_WIDTH   = 6
) (
    input  logic                       Clk_i,
    input  logic                       Rst_i,
    input  logic                       Empty_i,
    output logic                       Rd_En_o,
    input  logic [UART_DATA_WIDTH-1:0] RXD_Data_i,
    input  logic [1:0]                 Mode_i,
    input  logic                       HSync_i,
    input  logic                       VSync_i,
    input  logic                       Pixel_En_i,
    output logic [REG_IDX_WIDTH-1:0]   C_Addr_o,
    output logic [COLOR_WIDTH-1:0]     C_Data_o,
    output logic                       C_Valid_o,
    input  logic                       C_Rdy_i,
    output logic [REG_IDX_WIDTH-1:0]   Config_Notification_o,
    output logic                       Config_Notification_Valid_o,
    output logic [1:0]                 Config_Error_o,
    output logic                       Error_Valid_o,
    output logic [COLOR_WIDTH-1:0]     Data_VGA_o
);

    localparam int COLOR_BYTES = colorBytes(COLOR_WIDTH);
    localparam int NUM_REGIONS = H_REGIONS * V_REGIONS;
    localparam int TBL_IDX_W   = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
    localparam int TBL_DEPTH   = 2 ** TBL_IDX_W;
    localparam int CNT_W       = $clog2(COLOR_BYTES + 1);

    state_e                   state_q, state_d;
    logic [REG_IDX_WIDTH-1:0] addr_q, addr_d;
    logic [COLOR_WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     inFrame_q, inFrame_d;
    logic                     discard_q, discard_d;
    logic                     errValid_q, errValid_d;
    err_e                     errCode_q, errCode_d;

    logic                     isHeader;
    logic                     hdrInRange;
    logic                     firstData;
    logic                     tblWrite;

    assign isHeader   = (RXD_Data_i[7:6] == HDR_TAG);
    assign hdrInRange = (int'(RXD_Data_i[5:0]) < NUM_REGIONS);
    assign firstData  = (cnt_q == CNT_W'(COLOR_BYTES));
    assign tblWrite   = (state_q == ST_WRITE) && C_Rdy_i;

    always_ff @(posedge Clk_i or negedge Rst_i) begin
        if (!Rst_i) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            inFrame_q  <= 1'b0;
            discard_q  <= 1'b0;
            errValid_q <= 1'b0;
            errCode_q  <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            inFrame_q  <= inFrame_d;
            discard_q  <= discard_d;
            errValid_q <= errValid_d;
            errCode_q  <= errCode_d;
        end
    end

    // Every byte goes IDLE -> POP -> HDR/DATA; the byte is evaluated the cycle after Rd_En.
    // A header can only be told apart from the top data byte, whose unused upper bits are zero.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        inFrame_d  = inFrame_q;
        discard_d  = discard_q;
        errValid_d = 1'b0;
        errCode_d  = ERR_NONE;
        case (state_q)
            ST_IDLE: begin
                if (!Empty_i) state_d = ST_POP;
            end
            ST_POP: begin
                state_d = inFrame_q ? ST_DATA : ST_HDR;
            end
            ST_HDR, ST_DATA: begin
                state_d = ST_IDLE;
                if (state_q == ST_HDR && !isHeader) begin
                    errValid_d = 1'b1;
                    errCode_d  = ERR_STRAY;
                end else if (isHeader && (state_q == ST_HDR || firstData)) begin
                    inFrame_d = 1'b1;
                    discard_d = !hdrInRange;
                    acc_d     = '0;
                    cnt_d     = CNT_W'(COLOR_BYTES);
                    if (hdrInRange) addr_d = REG_IDX_WIDTH'(RXD_Data_i[5:0]);
                    if (state_q == ST_DATA) begin
                        errValid_d = 1'b1;
                        errCode_d  = ERR_RESTART;
                    end else if (!hdrInRange) begin
                        errValid_d = 1'b1;
                        errCode_d  = ERR_RANGE;
                    end
                end else if (firstData && RXD_Data_i[7]) begin
                    inFrame_d  = 1'b0;
                    discard_d  = 1'b0;
                    errValid_d = 1'b1;
                    errCode_d  = ERR_STRAY;
                end else begin
                    acc_d = COLOR_WIDTH'({acc_q, RXD_Data_i});
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        inFrame_d = 1'b0;
                        discard_d = 1'b0;
                        if (!discard_q) state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (C_Rdy_i) state_d = ST_NOTIFY;
            end
            ST_NOTIFY: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        Rd_En_o                     = 1'b0;
        C_Valid_o                   = 1'b0;
        C_Addr_o                    = '0;
        C_Data_o                    = '0;
        Config_Notification_Valid_o = 1'b0;
        Config_Notification_o       = '0;
        case (state_q)
            ST_POP: Rd_En_o = 1'b1;
            ST_WRITE: begin
                C_Valid_o = 1'b1;
                C_Addr_o  = addr_q;
                C_Data_o  = acc_q;
            end
            ST_NOTIFY: begin
                Config_Notification_Valid_o = 1'b1;
                Config_Notification_o       = addr_q;
            end
            default: ;
        endcase
    end

    assign Error_Valid_o  = errValid_q;
    assign Config_Error_o = errCode_q;

    logic [REGION_IDX_W-1:0]  colIdx, rowIdx;
    logic [REG_IDX_WIDTH-1:0] regionSel;
    logic [TBL_IDX_W-1:0]     rdIdx, wrIdx;
    mode_e                    mode_q;
    logic [COLOR_WIDTH-1:0]   dataVga_q;
    logic [COLOR_WIDTH-1:0]   activeTbl_q [TBL_DEPTH];

    // VSync starts line 0 of the frame, so it must not also advance the row.
    color_grid_region_counter #(
        .REGIONS (H_REGIONS),
        .SPAN    (H_ACTIVE / H_REGIONS)
    ) u_colCounter (
        .clk_i   (Clk_i),
        .rst_ni  (Rst_i),
        .clear_i (HSync_i | VSync_i),
        .step_i  (Pixel_En_i),
        .idx_o   (colIdx)
    );

    color_grid_region_counter #(
        .REGIONS (V_REGIONS),
        .SPAN    (V_ACTIVE / V_REGIONS)
    ) u_rowCounter (
        .clk_i   (Clk_i),
        .rst_ni  (Rst_i),
        .clear_i (VSync_i),
        .step_i  (HSync_i),
        .idx_o   (rowIdx)
    );

    always_comb begin
        regionSel = '0;
        case (mode_q)
            MODE_SINGLE: regionSel = '0;
            MODE_VSPLIT: regionSel = REG_IDX_WIDTH'(colIdx);
            MODE_HSPLIT: regionSel = REG_IDX_WIDTH'(int'(rowIdx) * H_REGIONS);
            MODE_GRID:   regionSel = REG_IDX_WIDTH'(int'(rowIdx) * H_REGIONS + int'(colIdx));
            default:     regionSel = '0;
        endcase
    end

    assign rdIdx = TBL_IDX_W'(regionSel);
    assign wrIdx = TBL_IDX_W'(addr_q);

    always_ff @(posedge Clk_i or negedge Rst_i) begin
        if (!Rst_i) begin
            mode_q    <= MODE_SINGLE;
            dataVga_q <= '0;
        end else begin
            if (VSync_i) mode_q <= mode_e'(Mode_i);
            dataVga_q <= Pixel_En_i ? activeTbl_q[rdIdx] : '0;
        end
    end

`ifdef COLOR_GRID_SHADOW_EN
    logic [COLOR_WIDTH-1:0] shadowTbl_q [TBL_DEPTH];

    // The copy reads the pre-edge shadow, so a write coinciding with VSync waits a frame.
    always_ff @(posedge Clk_i or negedge Rst_i) begin
        if (!Rst_i) begin
            for (int i = 0; i < TBL_DEPTH; i++) begin
                shadowTbl_q[i] <= '0;
                activeTbl_q[i] <= '0;
            end
        end else begin
            if (tblWrite) shadowTbl_q[wrIdx] <= acc_q;
            if (VSync_i) begin
                for (int i = 0; i < TBL_DEPTH; i++) activeTbl_q[i] <= shadowTbl_q[i];
            end
        end
    end
`else
    always_ff @(posedge Clk_i or negedge Rst_i) begin
        if (!Rst_i) begin
            for (int i = 0; i < TBL_DEPTH; i++) activeTbl_q[i] <= '0;
        end else if (tblWrite) begin
            activeTbl_q[wrIdx] <= acc_q;
        end
    end
`endif

    assign Data_VGA_o = dataVga_q;

endmodule

// File: tb/tb_color_grid_manager.sv
// Directed bench for color_grid_manager: a behavioural RX FIFO feeds command
// frames while pixel scans check which colour each screen position shows.
module tb_color_grid_manager;

   logic        clk = 1'b0;
   logic        rstN;
   logic        empty;
   logic        rdEn;
   logic [7:0]  rxData;
   logic [1:0]  mode;
   logic        hSync, vSync, pixelEn;
   logic [5:0]  cAddr;
   logic [11:0] cData;
   logic        cValid, cRdy;
   logic [5:0]  notif;
   logic        notifValid;
   logic [1:0]  cfgErr;
   logic        errValid;
   logic [11:0] dataVga;

   int          checks = 0;
   int          failures = 0;
   logic [7:0]  fifoQ[$];
   int          underflows = 0;
   int          notifyCount = 0;
   int          errCount = 0;
   logic [5:0]  lastNotify = '0;
   logic [1:0]  lastErr = '0;
   logic [5:0]  lastAddr = '0;
   logic [11:0] lastData = '0;
   logic [11:0] color;
   int          holdBad, popBad;

   always #5 clk = ~clk;

   color_grid_manager dut (
      .Clk_i                       (clk),
      .Rst_i                       (rstN),
      .Empty_i                     (empty),
      .Rd_En_o                     (rdEn),
      .RXD_Data_i                  (rxData),
      .Mode_i                      (mode),
      .HSync_i                     (hSync),
      .VSync_i                     (vSync),
      .Pixel_En_i                  (pixelEn),
      .C_Addr_o                    (cAddr),
      .C_Data_o                    (cData),
      .C_Valid_o                   (cValid),
      .C_Rdy_i                     (cRdy),
      .Config_Notification_o       (notif),
      .Config_Notification_Valid_o (notifValid),
      .Config_Error_o              (cfgErr),
      .Error_Valid_o               (errValid),
      .Data_VGA_o                  (dataVga)
   );

   // Non-FWFT FIFO model: a pop presents the head byte after the Rd_En cycle.
   always @(negedge clk) begin
      if (rdEn) begin
         if (fifoQ.size() > 0) rxData = fifoQ.pop_front();
         else underflows++;
      end
      empty = (fifoQ.size() == 0);
   end

   // Event monitor recording pulses and the last offered config write.
   always @(negedge clk) begin
      if (notifValid) begin
         notifyCount++;
         lastNotify = notif;
      end
      if (errValid) begin
         errCount++;
         lastErr = cfgErr;
      end
      if (cValid) begin
         lastAddr = cAddr;
         lastData = cData;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] b);
      fifoQ.push_back(b);
      empty = 1'b0;
   endtask

   task automatic sendFrame(input logic [7:0] hdr, input logic [7:0] d0, input logic [7:0] d1);
      applyStimulus(hdr);
      applyStimulus(d0);
      applyStimulus(d1);
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Starts a frame, advances to the given line and returns the colour of the given pixel.
   task automatic samplePixel(input int line, input int px, output logic [11:0] c);
      vSync = 1'b1;
      hSync = 1'b1;
      @(negedge clk);
      vSync = 1'b0;
      hSync = 1'b0;
      for (int l = 0; l < line; l++) begin
         hSync = 1'b1;
         @(negedge clk);
         hSync = 1'b0;
      end
      pixelEn = 1'b1;
      repeat (px) @(negedge clk);
      @(negedge clk);
      c = dataVga;
      pixelEn = 1'b0;
   endtask

   initial begin
      rstN = 1'b0;
      empty = 1'b1;
      rxData = '0;
      mode = 2'd0;
      hSync = 1'b0;
      vSync = 1'b0;
      pixelEn = 1'b0;
      cRdy = 1'b1;
      waitCycles(3);
      checkOutput("rstRdEn", rdEn, 0);
      checkOutput("rstCValid", cValid, 0);
      checkOutput("rstNotifValid", notifValid, 0);
      checkOutput("rstErrValid", errValid, 0);
      checkOutput("rstDataVga", dataVga, 0);
      rstN = 1'b1;
      waitCycles(2);

      $display("[TB] basic write to region 5");
      sendFrame(8'h85, 8'h0A, 8'hBC);
      waitCycles(40);
      checkOutput("wrNotifyCount", notifyCount, 1);
      checkOutput("wrNotifyIdx", lastNotify, 5);
      checkOutput("wrCAddr", lastAddr, 5);
      checkOutput("wrCData", lastData, 12'hABC);
      checkOutput("wrNoError", errCount, 0);
      mode = 2'd3;
      samplePixel(120, 160, color);
      checkOutput("region5Pixel", color, 12'hABC);
      samplePixel(0, 0, color);
      checkOutput("region0Pixel", color, 0);
      @(negedge clk);
      checkOutput("pixelEnLowZero", dataVga, 0);

      $display("[TB] backpressure on config port");
      cRdy = 1'b0;
      sendFrame(8'h81, 8'h01, 8'h23);
      for (int i = 0; i < 60 && !cValid; i++) @(negedge clk);
      checkOutput("bpValidRaised", cValid, 1);
      applyStimulus(8'h3F);
      holdBad = 0;
      popBad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (!cValid || cAddr != 6'd1 || cData != 12'h123) holdBad++;
         if (rdEn) popBad++;
      end
      checkOutput("bpHoldStable", holdBad, 0);
      checkOutput("bpNoPop", popBad, 0);
      checkOutput("bpFifoKept", fifoQ.size(), 1);
      cRdy = 1'b1;
      waitCycles(40);
      checkOutput("bpNotifyCount", notifyCount, 2);
      checkOutput("bpNotifyIdx", lastNotify, 1);

      $display("[TB] framing errors");
      checkOutput("strayErrCount", errCount, 1);
      checkOutput("strayErrCode", lastErr, 1);
      sendFrame(8'h9F, 8'h01, 8'h02);
      waitCycles(40);
      checkOutput("rangeErrCount", errCount, 2);
      checkOutput("rangeErrCode", lastErr, 2);
      checkOutput("rangeConsumed", fifoQ.size(), 0);
      checkOutput("rangeNoWrite", notifyCount, 2);
      applyStimulus(8'h82);
      sendFrame(8'h84, 8'h0F, 8'hFF);
      waitCycles(50);
      checkOutput("restartErrCount", errCount, 3);
      checkOutput("restartErrCode", lastErr, 3);
      checkOutput("restartNotifyCount", notifyCount, 3);
      checkOutput("restartIdx", lastNotify, 4);
      checkOutput("restartData", lastData, 12'hFFF);

      $display("[TB] region mapping");
      sendFrame(8'h81, 8'h00, 8'h01);
      sendFrame(8'h83, 8'h00, 8'h03);
      sendFrame(8'h84, 8'h00, 8'h04);
      sendFrame(8'h8F, 8'h0E, 8'hEE);
      waitCycles(120);
      checkOutput("mapNotifyCount", notifyCount, 7);
      mode = 2'd3;
      samplePixel(0, 160, color);
      checkOutput("gridL0P160", color, 12'h001);
      samplePixel(120, 0, color);
      checkOutput("gridL120P0", color, 12'h004);
      samplePixel(479, 639, color);
      checkOutput("gridLastPixel", color, 12'hEEE);
      mode = 2'd1;
      samplePixel(300, 480, color);
      checkOutput("vsplitL300P480", color, 12'h003);
      mode = 2'd2;
      samplePixel(130, 600, color);
      checkOutput("hsplitL130P600", color, 12'h004);

      $display("[TB] write visibility");
      mode = 2'd3;
      vSync = 1'b1;
      hSync = 1'b1;
      @(negedge clk);
      vSync = 1'b0;
      hSync = 1'b0;
      sendFrame(8'h80, 8'h05, 8'h55);
      waitCycles(40);
      checkOutput("visNotifyCount", notifyCount, 8);
      hSync = 1'b1;
      @(negedge clk);
      hSync = 1'b0;
      pixelEn = 1'b1;
      @(negedge clk);
      color = dataVga;
      pixelEn = 1'b0;
`ifdef COLOR_GRID_SHADOW_EN
      checkOutput("visBeforeVsync", color, 0);
`else
      checkOutput("visBeforeVsync", color, 12'h555);
`endif
      samplePixel(0, 0, color);
      checkOutput("visAfterVsync", color, 12'h555);
      mode = 2'd0;
      samplePixel(300, 600, color);
      checkOutput("singleL300P600", color, 12'h555);

      $display("[TB] reset mid-frame");
      applyStimulus(8'h85);
      applyStimulus(8'h01);
      waitCycles(20);
      rstN = 1'b0;
      @(negedge clk);
      checkOutput("midRstRdEn", rdEn, 0);
      checkOutput("midRstCValid", cValid, 0);
      checkOutput("midRstErrValid", errValid, 0);
      rstN = 1'b1;
      waitCycles(2);
      mode = 2'd3;
      samplePixel(120, 160, color);
      checkOutput("midRstRegion5", color, 0);
      sendFrame(8'h85, 8'h02, 8'h34);
      waitCycles(40);
      checkOutput("postRstNoError", errCount, 3);
      checkOutput("postRstNotifyCount", notifyCount, 9);
      checkOutput("postRstData", lastData, 12'h234);
      samplePixel(120, 160, color);
      checkOutput("postRstRegion5", color, 12'h234);
      checkOutput("noUnderflow", underflows, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/color_grid_manager.md
Name: color_grid_manager

Overview:
- Parametrised successor to the single-quadrant colour manager.
- Pops framed colour commands from the UART RX FIFO and stores one colour per region of an H_REGIONS x V_REGIONS screen grid.
- Mirrors each accepted write to the external config port using a valid/ready handshake.
- Drives Data_VGA per pixel from region counters that track HSync, VSync and Pixel_En. Sits between the UART RX FIFO and the VGA timing/output stage.

Parameters:
UART_DATA_WIDTH, 8, RX byte width
COLOR_WIDTH, 12, colour word width; COLOR_BYTES = ceil(COLOR_WIDTH/8), localparam
H_REGIONS, 4, grid columns, 1..8
V_REGIONS, 4, grid rows, 1..8
H_ACTIVE, 640, active pixels per line; must divide evenly by H_REGIONS
V_ACTIVE, 480, active lines per frame; must divide evenly by V_REGIONS
REG_IDX_WIDTH, 6, region index width; H_REGIONS*V_REGIONS <= 2**REG_IDX_WIDTH

Ports:
Clk  in  1  system clock
Rst  in  1  asynchronous, active-low reset
Empty  in  1  RX FIFO empty
Rd_En  out  1  RX FIFO pop; one-cycle pulse
RXD_Data  in  UART_DATA_WIDTH  FIFO head byte, valid while Empty=0
Mode  in  2  0 = single colour, 1 = vertical split, 2 = horizontal split, 3 = full grid
HSync  in  1  one-cycle pulse at line start
VSync  in  1  one-cycle pulse at frame start
Pixel_En  in  1  active-pixel strobe
C_Addr  out  REG_IDX_WIDTH  external config address
C_Data  out  COLOR_WIDTH  external config data
C_Valid  out  1  external config write valid
C_Rdy  in  1  external config ready
Config_Notification  out  REG_IDX_WIDTH  index of the region just written
Config_Notification_Valid  out  1  one-cycle pulse
Config_Error  out  2  1 = stray data byte, 2 = index out of range, 3 = frame restarted
Error_Valid  out  1  one-cycle pulse
Data_VGA  out  COLOR_WIDTH  pixel colour

Behaviour:
- Reset: all outputs 0, all region colours 0, counters 0, FSM in IDLE.
- Frame format:
  - Header byte has [7:6]=2'b10; [5:0] is the region index.
  - Followed by COLOR_BYTES data bytes, MSB first, each with [7]=0. The top byte is truncated to the remaining bits.
- FSM states: IDLE, POP, HDR, DATA, WRITE, NOTIFY.
  - IDLE: when Empty=0, pulse Rd_En and go to POP. RXD_Data is sampled the cycle after Rd_En.
  - HDR: on a valid index, go to DATA.
  - HDR, non-header byte: Error 1, drop the byte, return to IDLE.
  - HDR, index >= H_REGIONS*V_REGIONS: Error 2, discard the whole frame (its data bytes are still popped).
  - DATA: shift bytes into an accumulator.
  - DATA, header byte arrives: Error 3, restart the frame with the new header.
  - After the last byte, go to WRITE.
- WRITE:
  - Assert C_Valid and hold C_Addr/C_Data stable until C_Valid & C_Rdy.
  - No FIFO pop while in WRITE (backpressure).
  - On the handshake, update the region table, then go to NOTIFY.
- NOTIFY: pulse Config_Notification_Valid for one cycle, then go to IDLE.
- Pixel path:
  - Sub-counter counts Pixel_En up to H_ACTIVE/H_REGIONS-1, then increments the column, saturating at H_REGIONS-1.
  - HSync clears the column and sub-counter and advances the row sub-counter. Row logic mirrors column logic, with lines counted on HSync.
  - VSync clears everything and has priority over a simultaneous HSync.
- Region selection:
  - Mode 0: region 0.
  - Mode 1: column only, row 0.
  - Mode 2: row only, column 0.
  - Mode 3: row*H_REGIONS + column.
  - Mode is latched at VSync.
- Data_VGA is registered with 1-cycle latency after Pixel_En, and is 0 when Pixel_En=0.
- A table write and a pixel read in the same cycle return the old colour.
- Reset mid-frame or mid-handshake aborts immediately. No partial table update.

Optional Feature:
- Macro: COLOR_GRID_SHADOW_EN.
- Defined: writes go to a shadow table, which is copied to the active table on VSync, giving tear-free updates. A write and a VSync in the same cycle land in the next frame.
- Undefined: a single table; writes are visible on the next pixel.

Decomposition:
- Package color_grid_pkg holds:
  - header-tag constant 2'b10;
  - error codes;
  - Mode encodings;
  - FSM state enum;
  - COLOR_BYTES function.
- One sub-module: color_grid_region_counter, instantiated once for columns and once for rows (sub-counter plus saturating index).

Test Plan:
- Header 0x85, data 0x0A, 0xBC, C_Rdy=1 -> C_Addr=5, C_Data=0xABC, Config_Notification=5 pulse; region 5 pixels show 0xABC.
- C_Rdy held 0 for 10 cycles -> C_Valid held, C_Addr/C_Data stable, Rd_En=0 throughout, even with Empty=0.
- Byte 0x3F in IDLE -> Error 1. Header 0x9F with a 4x4 grid -> Error 2 and both data bytes consumed. Header then header -> Error 3 and the second frame is accepted.
- Mode 3, colours set to region index: line 0 pixel 160 -> region 1; line 120 pixel 0 -> region 4. Mode 1, line 300 pixel 480 -> region 3.
- With COLOR_GRID_SHADOW_EN: write mid-frame -> unchanged until VSync, new colour on the first pixel after it. Without it: new colour on the next pixel.
- Assert Rst=0 during DATA -> all outputs 0 and the table unchanged; the next full frame is processed normally.
